regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters (req0: ALU, req1: load/CSR) using round-robin arbitration with valid/ready handshakes.
- Drives the register file's write_sel, data_in and write_en from registers.
- Keeps a pending-write scoreboard (busy bitmap): issue reserves a destination, the granted write clears it. Decode stalls on busyA/busyB.

Parameters:
- XLEN, 32, data width
- NUM_REGS, 32, number of architectural registers
- SEL_W, 5, register select width, equal to clog2(NUM_REGS)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a write
- req0_sel  in  SEL_W  requester 0 destination
- req0_data  in  XLEN  requester 0 data
- req0_ready  out  1  requester 0 granted this cycle
- req1_valid  in  1  requester 1 has a write
- req1_sel  in  SEL_W  requester 1 destination
- req1_data  in  XLEN  requester 1 data
- req1_ready  out  1  requester 1 granted this cycle
- rsv_en  in  1  reserve a destination at issue
- rsv_sel  in  SEL_W  register to reserve
- rd_selA  in  SEL_W  decode read select A
- rd_selB  in  SEL_W  decode read select B
- busyA  out  1  scoreboard bit for rd_selA
- busyB  out  1  scoreboard bit for rd_selB
- rf_write_sel  out  SEL_W  to register file write_sel
- rf_data_in  out  XLEN  to register file data_in
- rf_write_en  out  1  to register file write_en
- byp_hitA  out  1  bypass hit on A (optional feature)
- byp_hitB  out  1  bypass hit on B (optional feature)
- byp_data  out  XLEN  bypass data (optional feature)

Behaviour:
- Reset (async, rst=1):
  - rf_write_en=0, rf_write_sel=0, rf_data_in=0.
  - Busy bitmap all 0.
  - last_grant=1, so req0 wins the first conflict.
  - While rst=1, req*_ready=0.
- Arbitration (combinational ready):
  - Only req0_valid: req0_ready=1.
  - Only req1_valid: req1_ready=1.
  - Both valid: grant the requester not equal to last_grant.
  - At most one ready is high. ready never asserts without the matching valid.
- Transfer occurs at the posedge where valid&&ready.
  - last_grant updates only on a transfer.
  - A requester holds sel/data stable until its transfer.
- Write stage, one register:
  - On transfer, rf_write_sel/rf_data_in load the winner's sel/data.
  - rf_write_en=1 for exactly the next cycle, and only if sel!=0.
  - With no transfer, rf_write_en=0; sel/data hold their previous value.
  - Latency: handshake at posedge N, register file write at the negedge inside cycle N+1.
  - Throughput: one write per cycle, back-to-back allowed.
- x0 handling:
  - Writes to sel 0 are accepted (ready=1) and consumed, but rf_write_en stays 0.
  - Busy bit 0 is hardwired 0; reserving 0 has no effect.
- Scoreboard, updated at posedge:
  - Transfer with sel=r clears bit r.
  - rsv_en with rsv_sel=r sets bit r.
  - Same r in the same cycle: set wins, because the new reservation is younger.
  - busyA = bitmap[rd_selA], busyB = bitmap[rd_selB]; combinational from current state.
  - Reserving an already busy register keeps it busy; no counting.
- Mid-operation reset clears the scoreboard and drops rf_write_en the same instant. Any unaccepted requests stay pending on the requester side.

Optional Feature:
- Macro: REGFILE_ARB_BYPASS_EN
- Defined:
  - byp_hitA = rf_write_en && (rf_write_sel==rd_selA); byp_hitB likewise.
  - byp_data = rf_data_in.
  - Covers the cycle where the register file has not yet committed the write for a posedge read.
- Undefined: byp_hitA, byp_hitB and byp_data are tied to 0; ports remain present.

Test Plan:
- Reset then idle: rf_write_en=0; busyA/busyB=0 for rd_selA=5, rd_selB=31; both readies 0 during rst.
- req0 only, sel=3, data=0xDEADBEEF: req0_ready=1; next cycle rf_write_en=1, rf_write_sel=3, rf_data_in=0xDEADBEEF; following cycle rf_write_en=0.
- Both valid for 4 cycles, req0 sel=1, req1 sel=2: grants alternate req0, req1, req0, req1; rf_write_sel sequence 1, 2, 1, 2; never both readies high.
- rsv_en sel=7, then rd_selA=7: busyA=1. req1 writes sel=7 with simultaneous rsv_en sel=7: busyA stays 1. Next write to 7 without reserve: busyA=0.
- req0 sel=0, data=0x1234: req0_ready=1, rf_write_en stays 0; rsv_en sel=0 leaves busy=0.
- REGFILE_ARB_BYPASS_EN defined, write sel=9 data=0xA5A5A5A5, rd_selB=9: byp_hitB=1 and byp_data=0xA5A5A5A5 in the rf_write_en cycle. Macro undefined: byp_hitB=0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters, the scoreboard/decode side and the register file.
// The arbiter takes the slave modport; the master modport is the driving side.
interface regfile_write_arbiter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SEL_W = 5
);
  logic             req0_valid;
  logic [SEL_W-1:0] req0_sel;
  logic [XLEN-1:0]  req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [SEL_W-1:0] req1_sel;
  logic [XLEN-1:0]  req1_data;
  logic             req1_ready;
  logic             rsv_en;
  logic [SEL_W-1:0] rsv_sel;
  logic [SEL_W-1:0] rd_selA;
  logic [SEL_W-1:0] rd_selB;
  logic             busyA;
  logic             busyB;
  logic [SEL_W-1:0] rf_write_sel;
  logic [XLEN-1:0]  rf_data_in;
  logic             rf_write_en;
  logic             byp_hitA;
  logic             byp_hitB;
  logic [XLEN-1:0]  byp_data;

  modport slave (
    input  req0_valid, req0_sel, req0_data,
    input  req1_valid, req1_sel, req1_data,
    input  rsv_en, rsv_sel, rd_selA, rd_selB,
    output req0_ready, req1_ready, busyA, busyB,
    output rf_write_sel, rf_data_in, rf_write_en,
    output byp_hitA, byp_hitB, byp_data
  );

  modport master (
    output req0_valid, req0_sel, req0_data,
    output req1_valid, req1_sel, req1_data,
    output rsv_en, rsv_sel, rd_selA, rd_selB,
    input  req0_ready, req1_ready, busyA, busyB,
    input  rf_write_sel, rf_data_in, rf_write_en,
    input  byp_hitA, byp_hitB, byp_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port with a pending-write busy scoreboard.
// Define REGFILE_ARB_BYPASS_EN to drive the write-stage bypass outputs (tied to 0 otherwise).
module regfile_write_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned SEL_W    = 5
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);

  // last_grant_q: 0 = req0 won the last transfer, 1 = req1 did
  logic                last_grant_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [SEL_W-1:0]    wsel_q;
  logic [XLEN-1:0]     wdata_q;
  logic                wen_q;

  logic                grant0, grant1, xfer;
  logic [SEL_W-1:0]    win_sel;
  logic [XLEN-1:0]     win_data;

  // Ready is held low during reset so nothing is consumed while state is being cleared.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign xfer     = grant0 | grant1;
  assign win_sel  = grant1 ? bus.req1_sel  : bus.req0_sel;
  assign win_data = grant1 ? bus.req1_data : bus.req0_data;

  // Reservation applied after the clear: a same-cycle reserve is the younger producer.
  always_comb begin
    busy_d = busy_q;
    if (xfer) begin
      busy_d[win_sel] = 1'b0;
    end
    if (bus.rsv_en) begin
      busy_d[bus.rsv_sel] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      busy_q       <= '0;
      wsel_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wen_q  <= xfer && (win_sel != '0);
      if (xfer) begin
        wsel_q       <= win_sel;
        wdata_q      <= win_data;
        last_grant_q <= grant1;
      end
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.busyA        = busy_q[bus.rd_selA];
  assign bus.busyB        = busy_q[bus.rd_selB];
  assign bus.rf_write_sel = wsel_q;
  assign bus.rf_data_in   = wdata_q;
  assign bus.rf_write_en  = wen_q;

`ifdef REGFILE_ARB_BYPASS_EN
  assign bus.byp_hitA = wen_q && (wsel_q == bus.rd_selA);
  assign bus.byp_hitB = wen_q && (wsel_q == bus.rd_selB);
  assign bus.byp_data = wdata_q;
`else
  assign bus.byp_hitA = 1'b0;
  assign bus.byp_hitB = 1'b0;
  assign bus.byp_data = '0;
`endif

endmodule
